// File: rtl/rename_regfile.sv
// Architectural register file with per-register rename tags, commit write-back and flush.
// Optional RF_CM_FWD_EN: forward a matching commit to the read ports in the same cycle.
module rename_regfile #(
  parameter int REG_NUM = 32,
  parameter int NAME_W  = 5,
  parameter int NICK_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              iclr,
  input  logic              iROB_nick_en,
  input  logic [NICK_W-1:0] iROB_nick,
  input  logic [NAME_W-1:0] iROB_nick_regnm,
  input  logic              iCM_en,
  input  logic [NAME_W-1:0] iCM_regnm,
  input  logic [DATA_W-1:0] iCM_dt,
  input  logic [NICK_W-1:0] iCM_nick,
  input  logic [NAME_W-1:0] iDP_rs1,
  input  logic [NAME_W-1:0] iDP_rs2,
  output logic              oDP_rs1_busy,
  output logic [NICK_W-1:0] oDP_rs1_nick,
  output logic [DATA_W-1:0] oDP_rs1_dt,
  output logic              oDP_rs2_busy,
  output logic [NICK_W-1:0] oDP_rs2_nick,
  output logic [DATA_W-1:0] oDP_rs2_dt,
  output logic [31:0]       oCM_cnt
);

  logic [DATA_W-1:0] data [REG_NUM];
  logic [NICK_W-1:0] tag  [REG_NUM];
  logic [REG_NUM-1:0] busy;
  logic [31:0]        cm_cnt;

  logic rename_fire;
  logic commit_wr;
  logic commit_match;

  assign rename_fire  = iROB_nick_en && !iclr && (iROB_nick_regnm != '0);
  assign commit_wr    = iCM_en && (iCM_regnm != '0);
  assign commit_match = commit_wr && busy[iCM_regnm] && (tag[iCM_regnm] == iCM_nick);

  // Later assignments win: rename overrides a same-register commit release, flush overrides both.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= '0;
      cm_cnt <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        data[i] <= '0;
        tag[i]  <= '0;
      end
    end else if (rdy) begin
      if (iCM_en) begin
        cm_cnt <= cm_cnt + 32'd1;
      end
      if (commit_wr) begin
        data[iCM_regnm] <= iCM_dt;
      end
      if (commit_match) begin
        busy[iCM_regnm] <= 1'b0;
        tag[iCM_regnm]  <= '0;
      end
      if (rename_fire) begin
        busy[iROB_nick_regnm] <= 1'b1;
        tag[iROB_nick_regnm]  <= iROB_nick;
      end
      if (iclr) begin
        busy <= '0;
        for (int i = 0; i < REG_NUM; i++) begin
          tag[i] <= '0;
        end
      end
    end
  end

  assign oCM_cnt = cm_cnt;

  always_comb begin
    oDP_rs1_busy = 1'b0;
    oDP_rs1_nick = '0;
    oDP_rs1_dt   = '0;
    if (iDP_rs1 != '0) begin
      if (busy[iDP_rs1]) begin
        oDP_rs1_busy = 1'b1;
        oDP_rs1_nick = tag[iDP_rs1];
      end else begin
        oDP_rs1_dt = data[iDP_rs1];
      end
`ifdef RF_CM_FWD_EN
      if (commit_match && (iCM_regnm == iDP_rs1)) begin
        oDP_rs1_busy = 1'b0;
        oDP_rs1_nick = '0;
        oDP_rs1_dt   = iCM_dt;
      end
`endif
    end
  end

  always_comb begin
    oDP_rs2_busy = 1'b0;
    oDP_rs2_nick = '0;
    oDP_rs2_dt   = '0;
    if (iDP_rs2 != '0) begin
      if (busy[iDP_rs2]) begin
        oDP_rs2_busy = 1'b1;
        oDP_rs2_nick = tag[iDP_rs2];
      end else begin
        oDP_rs2_dt = data[iDP_rs2];
      end
`ifdef RF_CM_FWD_EN
      if (commit_match && (iCM_regnm == iDP_rs2)) begin
        oDP_rs2_busy = 1'b0;
        oDP_rs2_nick = '0;
        oDP_rs2_dt   = iCM_dt;
      end
`endif
    end
  end

endmodule
